spi_config_regbank: RTL and testbench

Parametrised SPI-mode-0 configuration register bank, the successor to the single 32-bit configuration word that the VGA GPU top loads from its SPI peripheral. It holds `NUM_REGS` registers of `REG_WIDTH` bits, addressed by a command byte and supporting auto-incrementing bursts and readback on `miso`. Writes land in shadow registers and are committed to the active outputs either immediately or on a frame-sync pulse, so pixel-mux and character-memory controls change only between frames.

---
 rtl/spi_cfg_pkg.sv | 26 ++
 rtl/spi_config_regbank_sync.sv | 28 ++
 rtl/spi_config_regbank.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_config_regbank.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration register bank.
// Holds the FSM encoding, command-byte layout and default reset word.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_e;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_W    = 7;

    localparam logic [31:0] DEF_RESET_WORD = 32'hBBFC_0000;

    localparam logic [CMD_ADDR_W-1:0] ADDR_ONE = CMD_ADDR_W'(1);

    // Burst address step: wraps to 0 after the last implemented register.
    function automatic logic [CMD_ADDR_W-1:0] next_addr(
        input logic [CMD_ADDR_W-1:0] a,
        input logic [CMD_ADDR_W-1:0] last
    );
        return (a == last) ? '0 : a + ADDR_ONE;
    endfunction

endpackage

// File: rtl/spi_config_regbank_sync.sv
// 2-FF synchroniser with registered history for rise/fall pulse detection.
// Used for the asynchronous SPI pins entering the pixel-clock domain.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {3{RST_VAL}};
        end else begin
            sr_q <= {sr_q[1:0], d_i};
        end
    end

    assign q_o    = sr_q[1];
    assign rise_o = sr_q[1] & ~sr_q[2];
    assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_config_regbank.sv
// SPI mode-0 configuration register bank with shadow/active copies,
// auto-incrementing bursts, readback on miso and frame-synchronous commit.
module spi_config_regbank
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int REG_WIDTH = 32,
    parameter bit COMMIT_ON_FRAME = 1'b1,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE =
        {NUM_REGS{DEF_RESET_WORD}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          ss,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          miso_oe,
    input  logic                          frame_sync,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_out,
    output logic                          commit_pending,
    output logic                          addr_err
);

    localparam int NBYTES = REG_WIDTH / 8;
    localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [BCW-1:0] BYTE_ONE = BCW'(1);
    localparam logic [CMD_ADDR_W-1:0] LAST_ADDR = CMD_ADDR_W'(NUM_REGS - 1);
    localparam logic [CMD_ADDR_W:0] NREGS = (CMD_ADDR_W + 1)'(NUM_REGS);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_ok;

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [REG_WIDTH-1:0] rx_q, rx_d;
    logic [REG_WIDTH-1:0] tx_q, tx_d;
    logic [CMD_ADDR_W-1:0] addr_q, addr_d;
    logic wr_q, wr_d;
    logic miso_q, miso_d;
    logic pend_q, pend_d;
    logic err_q, err_d;

    logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [REG_WIDTH-1:0] shadow_d [NUM_REGS];
    logic [REG_WIDTH-1:0] active_q [NUM_REGS];
    logic [REG_WIDTH-1:0] active_d [NUM_REGS];

    logic [7:0] cmd_byte;
    logic [CMD_ADDR_W-1:0] cmd_addr, addr_inc, rd_addr;
    logic [REG_WIDTH-1:0] word, rd_data;
    logic cmd_done, word_done, wr_en, commit;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ss),
        .q_o    (ss_s),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_ok = ^{sclk_s, ss_rise, mosi_rise, mosi_fall};

    function automatic logic in_range(input logic [CMD_ADDR_W-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    assign cmd_byte = {rx_q[6:0], mosi_s};
    assign cmd_addr = cmd_byte[CMD_ADDR_W-1:0];
    assign word     = {rx_q[REG_WIDTH-2:0], mosi_s};
    assign addr_inc = next_addr(addr_q, LAST_ADDR);

    // Reads load at the end of the command byte, then at each word boundary.
    assign rd_addr = (state_q == CMD) ? cmd_addr : addr_inc;
    assign rd_data = in_range(rd_addr) ? active_q[rd_addr[IW-1:0]] : '0;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        miso_d     = miso_q;
        err_d      = err_q;
        cmd_done   = 1'b0;
        word_done  = 1'b0;
        if (ss_s) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            tx_d       = '0;
            miso_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_d    = CMD;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d      = word;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_done   = 1'b1;
                            state_d    = DATA;
                            wr_d       = cmd_byte[CMD_WRITE_BIT];
                            addr_d     = cmd_addr;
                            byte_cnt_d = '0;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_d      = word;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == LAST_BYTE) begin
                                word_done  = 1'b1;
                                byte_cnt_d = '0;
                                addr_d     = addr_inc;
                            end else begin
                                byte_cnt_d = byte_cnt_q + BYTE_ONE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (sclk_fall && state_q != IDLE) begin
                miso_d = tx_q[REG_WIDTH-1];
                tx_d   = tx_q << 1;
            end
            if (cmd_done) begin
                tx_d = cmd_byte[CMD_WRITE_BIT] ? '0 : rd_data;
                if (!cmd_byte[CMD_WRITE_BIT] && !in_range(cmd_addr)) begin
                    err_d = 1'b1;
                end
            end
            if (word_done) begin
                if (wr_q) begin
                    if (!in_range(addr_q)) err_d = 1'b1;
                end else begin
                    tx_d = rd_data;
                    if (!in_range(addr_inc)) err_d = 1'b1;
                end
            end
        end
    end

    // Commit copies the pre-write shadows, so a colliding word waits.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        wr_en    = word_done && wr_q && in_range(addr_q);
        commit   = COMMIT_ON_FRAME && frame_sync && pend_q;
        if (commit) begin
            active_d = shadow_q;
        end
        if (wr_en) begin
            shadow_d[addr_q[IW-1:0]] = word;
            if (!COMMIT_ON_FRAME) begin
                active_d[addr_q[IW-1:0]] = word;
            end
        end
        if (!COMMIT_ON_FRAME) begin
            pend_d = 1'b0;
        end else if (wr_en) begin
            pend_d = 1'b1;
        end else if (commit) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            miso_q     <= 1'b0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
                active_q[i] <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            miso_q     <= miso_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*REG_WIDTH +: REG_WIDTH] = active_q[g];
    end

    assign miso           = miso_q;
    assign miso_oe        = ~ss_s;
    assign commit_pending = pend_q;
    assign addr_err       = err_q;

endmodule

// File: tb/tb_spi_config_regbank.sv
// Bench for spi_config_regbank: frame-commit and immediate-mode instances
// driven by one SPI master, checked against an array-based register model.
module tb_spi_config_regbank;

    localparam logic [127:0] RST_IMG = {4{32'hBBFC_0000}};
    localparam logic [127:0] IMM_RST =
        {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic ss = 1'b1;
    logic mosi = 1'b0;
    logic frame_sync = 1'b0;

    logic miso, miso_oe, pend, err;
    logic [127:0] regs;
    logic miso_b, oe_b, pend_b, err_b;
    logic [127:0] regs_b;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] tx_words[$];
    logic [31:0] rx_words[$];

    logic [31:0] sh_m [4];
    logic [31:0] act_m [4];
    logic [31:0] imm_m [4];
    bit pend_m, err_m;

    typedef struct {
        logic [7:0]  wcmd;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    spi_config_regbank #(
        .NUM_REGS(4), .REG_WIDTH(32), .COMMIT_ON_FRAME(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .frame_sync(frame_sync),
        .regs_out(regs), .commit_pending(pend), .addr_err(err)
    );

    spi_config_regbank #(
        .NUM_REGS(4), .REG_WIDTH(32), .COMMIT_ON_FRAME(1'b0),
        .RESET_VALUE(IMM_RST)
    ) u_imm (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso_b), .miso_oe(oe_b), .frame_sync(frame_sync),
        .regs_out(regs_b), .commit_pending(pend_b), .addr_err(err_b)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] act_img();
        return {act_m[3], act_m[2], act_m[1], act_m[0]};
    endfunction

    function automatic logic [127:0] imm_img();
        return {imm_m[3], imm_m[2], imm_m[1], imm_m[0]};
    endfunction

    function automatic logic [6:0] nxt(input logic [6:0] a);
        return (a == 7'd3) ? 7'd0 : a + 7'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_m[i]  = RST_IMG[i*32 +: 32];
            act_m[i] = RST_IMG[i*32 +: 32];
            imm_m[i] = IMM_RST[i*32 +: 32];
        end
        pend_m = 1'b0;
        err_m  = 1'b0;
    endtask

    task automatic model_write(input logic [6:0] a0, input int n);
        logic [6:0] a;
        a = a0;
        for (int k = 0; k < n; k++) begin
            if (a < 7'd4) begin
                sh_m[a[1:0]]  = tx_words[k];
                imm_m[a[1:0]] = tx_words[k];
                pend_m = 1'b1;
            end else begin
                err_m = 1'b1;
            end
            a = nxt(a);
        end
    endtask

    task automatic model_commit();
        if (pend_m) begin
            for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
            pend_m = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_regs"}, regs, act_img());
        check({tag, "_pend"}, 128'(pend), 128'(pend_m));
        check({tag, "_err"}, 128'(err), 128'(err_m));
        check({tag, "_imm_regs"}, regs_b, imm_img());
        check({tag, "_imm_pend"}, 128'(pend_b), 128'(0));
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #60;
        r = miso;
        sclk = 1'b1;
        #60;
        sclk = 1'b0;
    endtask

    // abort_at: data-bit index at which ss is raised (-1 = never).
    // collide: frame_sync lands on the cycle the final bit is sampled.
    task automatic spi_xfer(input logic [7:0] cmd, input int nwords,
                            input int abort_at, input bit collide);
        logic r;
        logic [31:0] w, rw;
        int bitno;
        bit stop;
        bitno = 0;
        stop = 1'b0;
        rw = '0;
        rx_words.delete();
        @(negedge clk);
        ss = 1'b0;
        #60;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r);
        for (int k = 0; k < nwords && !stop; k++) begin
            w = cmd[7] ? tx_words[k] : $urandom;
            for (int i = 31; i >= 0 && !stop; i--) begin
                if (bitno == abort_at) begin
                    stop = 1'b1;
                end else begin
                    if (collide && k == nwords - 1 && i == 0) begin
                        fork
                            begin
                                #80 frame_sync = 1'b1;
                                #10 frame_sync = 1'b0;
                            end
                        join_none
                    end
                    spi_bit(w[i], r);
                    rw[i] = r;
                    bitno++;
                end
            end
            if (!stop) rx_words.push_back(rw);
        end
        #60;
        ss = 1'b1;
        #100;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_sync = 1'b1;
        #1 check("pre_commit", regs, act_img());
        @(negedge clk);
        frame_sync = 1'b0;
        model_commit();
        check_state("commit");
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a, b;
        logic [7:0] cmdv;
        logic r;
        int n;
        bit wr;

        tbl[0] = '{8'h80, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
        tbl[1] = '{8'h82, 32'h1234_5678, 32'h1234_5678, 1'b0};
        tbl[2] = '{8'h83, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[3] = '{8'h81, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[4] = '{8'h90, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
        tbl[5] = '{8'hFF, 32'h1111_1111, 32'h0000_0000, 1'b1};

        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_regs", regs, RST_IMG);
        check("rst_imm_regs", regs_b, IMM_RST);
        check("rst_pend", 128'(pend), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_miso", 128'({miso, miso_b}), 128'(0));
        check("rst_oe", 128'({miso_oe, oe_b}), 128'(0));

        tx_words = '{32'hDEAD_BEEF};
        spi_xfer(8'h81, 1, -1, 1'b0);
        model_write(7'd1, 1);
        check("wr1_pend", 128'(pend), 128'(1));
        check("wr1_reg1_hold", 128'(regs[63:32]), 128'(32'hBBFC_0000));
        check("wr1_imm_reg1", 128'(regs_b[63:32]), 128'(32'hDEAD_BEEF));
        check_state("wr1");
        frame_pulse();
        check("wr1_reg1", 128'(regs[63:32]), 128'(32'hDEAD_BEEF));

        tx_words = '{32'hAAAA_0003, 32'hBBBB_0000, 32'hCCCC_0001};
        spi_xfer(8'h83, 3, -1, 1'b0);
        model_write(7'd3, 3);
        check_state("burst");
        frame_pulse();
        check("burst_reg3", 128'(regs[127:96]), 128'(32'hAAAA_0003));
        check("burst_reg0", 128'(regs[31:0]), 128'(32'hBBBB_0000));
        check("burst_reg1", 128'(regs[63:32]), 128'(32'hCCCC_0001));
        check("burst_reg2", 128'(regs[95:64]), 128'(32'hBBFC_0000));

        tx_words = '{32'h55AA_55AA};
        spi_xfer(8'h80, 1, 13, 1'b0);
        check_state("abort");
        tx_words = '{32'h0F0F_0F0F};
        spi_xfer(8'h82, 1, -1, 1'b0);
        model_write(7'd2, 1);
        check_state("post_abort");
        frame_pulse();

        tx_words = '{32'h1357_9BDF};
        spi_xfer(8'h80, 1, -1, 1'b0);
        model_write(7'd0, 1);
        tx_words = '{32'h2468_ACE0};
        spi_xfer(8'h81, 1, -1, 1'b1);
        model_commit();
        model_write(7'd1, 1);
        check("coll_reg0", 128'(regs[31:0]), 128'(32'h1357_9BDF));
        check("coll_reg1_hold", 128'(regs[63:32]), 128'(32'hCCCC_0001));
        check_state("collide");
        frame_pulse();
        check("coll_reg1", 128'(regs[63:32]), 128'(32'h2468_ACE0));

        for (int i = 0; i < 6; i++) begin
            tx_words = '{tbl[i].wdata};
            spi_xfer(tbl[i].wcmd, 1, -1, 1'b0);
            model_write(tbl[i].wcmd[6:0], 1);
            frame_pulse();
            spi_xfer({1'b0, tbl[i].wcmd[6:0]}, 1, -1, 1'b0);
            check("tbl_rd", 128'(rx_words[0]), 128'(tbl[i].exp_rd));
            check("tbl_err", 128'(err), 128'(tbl[i].exp_err));
        end

        for (int t = 0; t < 25; t++) begin
            wr = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 5));
            n = $urandom_range(1, 3);
            tx_words.delete();
            if (wr) begin
                for (int k = 0; k < n; k++) tx_words.push_back($urandom);
                spi_xfer({1'b1, a}, n, -1, 1'b0);
                model_write(a, n);
            end else begin
                spi_xfer({1'b0, a}, n, -1, 1'b0);
                b = a;
                for (int k = 0; k < n; k++) begin
                    check("rand_rd", 128'(rx_words[k]),
                          128'((b < 7'd4) ? act_m[b[1:0]] : 32'h0));
                    if (b >= 7'd4) err_m = 1'b1;
                    b = nxt(b);
                end
            end
            check_state("rand");
            if ($urandom_range(0, 2) == 0) frame_pulse();
        end

        tx_words = '{32'h7777_0002};
        spi_xfer(8'h82, 1, -1, 1'b0);
        model_write(7'd2, 1);
        check_state("pre_rst");
        cmdv = 8'h83;
        @(negedge clk);
        ss = 1'b0;
        #60;
        for (int i = 7; i >= 0; i--) spi_bit(cmdv[i], r);
        for (int i = 0; i < 10; i++) spi_bit(1'($urandom_range(0, 1)), r);
        #3;
        check("mid_oe", 128'(miso_oe), 128'(1));
        rst_n = 1'b0;
        #1;
        check("arst_regs", regs, RST_IMG);
        check("arst_imm_regs", regs_b, IMM_RST);
        check("arst_pend", 128'(pend), 128'(0));
        check("arst_err", 128'(err), 128'(0));
        check("arst_miso", 128'(miso), 128'(0));
        check("arst_oe", 128'(miso_oe), 128'(0));
        #20;
        ss = 1'b1;
        #50;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tx_words = '{32'h0BAD_F00D};
        spi_xfer(8'h80, 1, -1, 1'b0);
        model_write(7'd0, 1);
        check_state("post_rst");
        frame_pulse();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
